serial_subtractor_ctrl: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 The block SHALL provide parameter WIDTH: default 8; operand width in bits; legal range 2..32.
REQ-003 The block SHALL provide port clk: input, 1 bit; rising-edge clock for all state.
REQ-004 The block SHALL provide port rst: input, 1 bit; synchronous, active-high reset.
REQ-005 The block SHALL provide port Start: input, 1 bit; request to begin a subtraction.
REQ-006 The block SHALL provide port A: input, WIDTH bits; minuend, unsigned.
REQ-007 The block SHALL provide port B: input, WIDTH bits; subtrahend, unsigned.
REQ-008 The block SHALL provide port Busy: output, 1 bit; high while a subtraction is in progress.
REQ-009 The block SHALL provide port Done: output, 1 bit; one-cycle completion pulse.
REQ-010 The block SHALL provide port Diff: output, WIDTH bits; registered result, (A - B) mod 2^WIDTH.
REQ-011 The block SHALL provide port Borrow: output, 1 bit; registered final borrow, 1 iff A < B (unsigned).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-013 In IDLE, Start sampled high at a rising edge SHALL accept the request.
- A and B load into internal shift registers.
- The internal borrow flop clears to 0.
- The bit counter clears to 0.
- The state becomes RUN.
REQ-014 A and B SHALL be sampled only at the accepting edge; later changes on A and B SHALL have no effect on the operation in flight.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first, using a full-subtractor formed from two half-subtractor stages:
- d = a0 ^ b0 ^ bin
- bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
REQ-016 In RUN, each cycle SHALL shift d into the result register from the MSB side, register bout as the next bin, shift both operand registers right by 1, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the state SHALL become FINISH.
REQ-018 Entering FINISH SHALL load Diff with the completed result register and Borrow with the final bout.
REQ-019 In FINISH, Done SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE on the next edge.
REQ-020 Busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-021 Latency: if Start is accepted at edge E, Done SHALL be high during the cycle between edges E+WIDTH and E+WIDTH+1.
REQ-022 Start while Busy=1 SHALL be ignored; it SHALL NOT be queued and SHALL NOT disturb the operation in flight.
REQ-023 Start held continuously high SHALL start a new operation on the first edge after FINISH, so throughput is one result per WIDTH+2 cycles.
REQ-024 Diff and Borrow SHALL hold their last values until the next FINISH entry, including while a new operation runs.
REQ-025 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during RUN.
REQ-026 Equal operands SHALL yield Diff=0 and Borrow=0; no special-case logic is permitted (the result SHALL come from the serial datapath).

Reset
REQ-027 When rst=1 at an edge, the block SHALL enter IDLE and clear Busy, Done, Diff, Borrow, the counter, the borrow flop and the operand/result registers to 0.
REQ-028 Reset SHALL take priority over Start and over any in-flight operation; an aborted operation SHALL produce no Done pulse.
REQ-029 On the first edge with rst=0, Start high SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, A=8'd5, B=8'd3, Start pulsed at edge E -> Busy high from E; Done high after E+8; Diff=8'h02, Borrow=0.
REQ-031 A=8'd3, B=8'd5 -> Diff=8'hFE, Borrow=1; A=8'h00, B=8'h01 -> Diff=8'hFF, Borrow=1; A=B=8'hFF -> Diff=8'h00, Borrow=0.
REQ-032 Start re-pulsed with A=8'd9, B=8'd9 during RUN of a 5-3 operation -> ignored; the result is Diff=8'h02, Borrow=0, with a single Done pulse.
REQ-033 Start held high across two operations (8'd10-8'd1, then 8'd1-8'd10) -> Done pulses 10 cycles apart; results are 8'h09/Borrow 0, then 8'hF7/Borrow 1.
REQ-034 rst asserted for one edge at the 4th RUN cycle -> all outputs read 0 next cycle and no Done pulse occurs; a subsequent 7-2 operation gives Diff=8'h05, Borrow=0.
REQ-035 Exhaustive random check at WIDTH=4 over all 256 operand pairs -> Diff == (A-B) mod 16 and Borrow == (A<B) for every pair.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: Start loads A and B, one bit is processed
// per cycle LSB first, and Diff/Borrow are registered when the last bit is done.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 completed low bits; the final bit is merged when Diff loads.
  logic [WIDTH-2:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             hs_d;
  logic             hs_b;
  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] shifted;

  // Full subtractor from two half-subtractor stages on the current LSBs.
  always_comb begin
    hs_d    = a_q[0] ^ b_q[0];
    hs_b    = ~a_q[0] & b_q[0];
    fs_d    = hs_d ^ bin_q;
    fs_bout = hs_b | (~hs_d & bin_q);
    shifted = {fs_d, res_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = shifted[WIDTH-1:1];
        bin_d = fs_bout;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d   = shifted;
          borrow_d = fs_bout;
          state_d  = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    Busy   = (state_q != IDLE);
    Done   = (state_q == FINISH);
    Diff   = diff_q;
    Borrow = borrow_q;
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  logic       rst4, start4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .Start(start8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Diff(diff8), .Borrow(borrow8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .Start(start4), .A(a4), .B(b4),
    .Busy(busy4), .Done(done4), .Diff(diff4), .Borrow(borrow4)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: t counts edges since acceptance, -1 when idle.
  int         m8_t = -1;
  logic [7:0] m8_a, m8_b, m8_diff;
  logic       m8_borrow;
  int         m4_t = -1;
  logic [3:0] m4_a, m4_b, m4_diff;
  logic       m4_borrow;

  always @(posedge clk) begin
    if (rst8) begin
      m8_t = -1; m8_diff = '0; m8_borrow = 1'b0;
    end else if (m8_t < 0) begin
      if (start8) begin m8_t = 0; m8_a = a8; m8_b = b8; end
    end else begin
      m8_t++;
      if (m8_t == 8) begin
        m8_diff = m8_a - m8_b;
        m8_borrow = (m8_a < m8_b);
      end else if (m8_t == 9) begin
        m8_t = -1;
      end
    end
    if (rst4) begin
      m4_t = -1; m4_diff = '0; m4_borrow = 1'b0;
    end else if (m4_t < 0) begin
      if (start4) begin m4_t = 0; m4_a = a4; m4_b = b4; end
    end else begin
      m4_t++;
      if (m4_t == 4) begin
        m4_diff = m4_a - m4_b;
        m4_borrow = (m4_a < m4_b);
      end else if (m4_t == 5) begin
        m4_t = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", busy8, m8_t >= 0);
      check("done8", done8, m8_t == 8);
      check("diff8", diff8, m8_diff);
      check("borrow8", borrow8, m8_borrow);
      check("busy4", busy4, m4_t >= 0);
      check("done4", done4, m4_t == 4);
      check("diff4", diff4, m4_diff);
      check("borrow4", borrow4, m4_borrow);
    end
  end

  task automatic wait_idle8();
    int guard = 0;
    @(negedge clk);
    while (busy8 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("idle8_timeout", guard < 40, 1);
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input string tag);
    int k = 1;
    bit seen = 1'b0;
    wait_idle8();
    rst8 = 1'b0;
    start8 = 1'b1; a8 = a; b8 = b;
    while (k <= 30 && !seen) begin
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) seen = 1'b1; else k++;
    end
    check({tag, "_latency"}, k, 9);
    check({tag, "_diff"}, diff8, ed);
    check({tag, "_borrow"}, borrow8, eb);
  endtask

  initial begin
    int n_done, d1, d2;
    logic [7:0] r1, r2;
    logic r1b, r2b;
    logic [7:0] order [256];
    logic [7:0] tmp, ra, rb;

    rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_diff", diff8, 0);
    check("reset_borrow", borrow8, 0);
    rst8 = 1'b0; rst4 = 1'b0;

    run_op8(8'd5, 8'd3, 8'h02, 1'b0, "op5m3");
    run_op8(8'd3, 8'd5, 8'hFE, 1'b1, "op3m5");
    run_op8(8'h00, 8'h01, 8'hFF, 1'b1, "op0m1");
    run_op8(8'hFF, 8'hFF, 8'h00, 1'b0, "opFFmFF");

    // Start re-pulsed mid-run must be ignored.
    wait_idle8();
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd3;
    n_done = 0; r1 = '0; r1b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start8 = (k == 3);
      a8 = (k == 3) ? 8'd9 : 8'($urandom);
      b8 = (k == 3) ? 8'd9 : 8'($urandom);
      if (done8) begin n_done++; r1 = diff8; r1b = borrow8; end
    end
    check("ignore_ndone", n_done, 1);
    check("ignore_diff", r1, 8'h02);
    check("ignore_borrow", r1b, 0);

    // Start held high across two operations.
    wait_idle8();
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd1;
    n_done = 0; d1 = 0; d2 = 0;
    r1 = '0; r2 = '0; r1b = 1'b0; r2b = 1'b0;
    for (int k = 1; k <= 40 && n_done < 2; k++) begin
      @(negedge clk);
      a8 = 8'd1; b8 = 8'd10;
      if (done8) begin
        n_done++;
        if (n_done == 1) begin d1 = k; r1 = diff8; r1b = borrow8; end
        else begin d2 = k; r2 = diff8; r2b = borrow8; start8 = 1'b0; end
      end
    end
    start8 = 1'b0;
    check("held_ndone", n_done, 2);
    check("held_spacing", d2 - d1, 10);
    check("held_diff1", r1, 8'h09);
    check("held_borrow1", r1b, 0);
    check("held_diff2", r2, 8'hF7);
    check("held_borrow2", r2b, 1);

    // Reset during the 4th RUN cycle aborts with no Done.
    wait_idle8();
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", diff8, 0);
    check("abort_borrow", borrow8, 0);
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    check("abort_ndone", n_done, 0);
    // Start accepted on the first edge after reset releases.
    rst8 = 1'b1;
    run_op8(8'd7, 8'd2, 8'h05, 1'b0, "op7m2");

    // Random operations with random gaps.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if (i % 5 == 0) rb = ra;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_op8(ra, rb, ra - rb, ra < rb, "rnd8");
    end
    // Random Start/operand noise, checked only by the per-cycle model.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      start8 = 1'($urandom_range(1, 0));
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    start8 = 1'b0;

    // All 256 operand pairs at WIDTH=4, in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      int k = 0;
      tmp = order[i];
      @(negedge clk);
      while (busy4 && k < 20) begin @(negedge clk); k++; end
      start4 = 1'b1; a4 = tmp[7:4]; b4 = tmp[3:0];
      k = 0;
      while (k < 20) begin
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        if (done4) break;
        k++;
      end
      check("ex4_done_seen", k < 20, 1);
      check("ex4_diff", diff4, 4'(tmp[7:4] - tmp[3:0]));
      check("ex4_borrow", borrow4, tmp[7:4] < tmp[3:0]);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
